// File: rtl/dct8x8_2d_seq_if.sv
// Handshake bundle for the 8x8 2-D DCT sequencer: row input, 1-D unit port, column output.
// The slave view is the sequencer; the master view is its environment.
interface dct8x8_2d_seq_if #(
    parameter int W = 16,
    parameter int N = 8
);
    logic           in_valid;
    logic           in_ready;
    logic [N*W-1:0] in_row;
    logic           dct_start;
    logic [N*W-1:0] dct_x;
    logic [N*W-1:0] dct_X;
    logic           dct_done;
    logic           out_valid;
    logic           out_ready;
    logic [N*W-1:0] out_col;
    logic [2:0]     out_idx;
    logic           out_last;
    logic           busy;

    modport slave (
        input  in_valid, in_row, dct_X, dct_done, out_ready,
        output in_ready, dct_start, dct_x, out_valid, out_col, out_idx, out_last, busy
    );

    modport master (
        output in_valid, in_row, dct_X, dct_done, out_ready,
        input  in_ready, dct_start, dct_x, out_valid, out_col, out_idx, out_last, busy
    );
endinterface

// File: rtl/dct8x8_2d_seq.sv
// 8x8 2-D DCT sequencer: rows through a shared 1-D unit into a transpose buffer,
// then buffer columns back through the same unit and out with a valid/ready handshake.

// One transpose-buffer row; lane k of the column read is row k, element sel.
module dct8x8_2d_seq_lane #(
    parameter int W  = 16,
    parameter int N  = 8,
    parameter int CW = 3
) (
    input  logic                clk,
    input  logic                we,
    input  logic [N-1:0][W-1:0] wdata,
    input  logic [CW-1:0]       sel,
    output logic [W-1:0]        rdata
);
    logic [N-1:0][W-1:0] row_q;

    always_ff @(posedge clk) begin
        if (we) row_q <= wdata;
    end

    assign rdata = row_q[sel];
endmodule

module dct8x8_2d_seq #(
    parameter int W = 16,
    parameter int N = 8
) (
    input logic              clk,
    input logic              rst,
    dct8x8_2d_seq_if.slave   bus
);
    localparam int CW = $clog2(N);

    typedef enum logic [2:0] {ROW_ISSUE, ROW_WAIT, COL_ISSUE, COL_WAIT, COL_OUT} state_t;

    state_t              state, state_nxt;
    logic [CW-1:0]       cnt;
    logic                row_wr;
    logic [N-1:0][W-1:0] col_rd;
    logic [N-1:0][W-1:0] out_col_q;
    logic [2:0]          out_idx_q;
    logic                out_last_q;

    assign row_wr = (state == ROW_WAIT) && bus.dct_done;

    for (genvar k = 0; k < N; k++) begin : g_lane
        dct8x8_2d_seq_lane #(.W(W), .N(N), .CW(CW)) u_lane (
            .clk   (clk),
            .we    (row_wr && (cnt == CW'(k))),
            .wdata (bus.dct_X),
            .sel   (cnt),
            .rdata (col_rd[k])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) state <= ROW_ISSUE;
        else     state <= state_nxt;
    end

    // dct_done outside the two WAIT states never reaches a transition, so strays are dropped
    always_comb begin
        state_nxt = state;
        case (state)
            ROW_ISSUE: if (bus.in_valid)  state_nxt = ROW_WAIT;
            ROW_WAIT:  if (bus.dct_done)  state_nxt = (cnt == CW'(N-1)) ? COL_ISSUE : ROW_ISSUE;
            COL_ISSUE:                    state_nxt = COL_WAIT;
            COL_WAIT:  if (bus.dct_done)  state_nxt = COL_OUT;
            COL_OUT:   if (bus.out_ready) state_nxt = (cnt == CW'(N-1)) ? ROW_ISSUE : COL_ISSUE;
            default:                      state_nxt = ROW_ISSUE;
        endcase
    end

    // cnt is 3 bits with N fixed at 8, so 7+1 wraps to 0 for the next phase
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt        <= '0;
            out_col_q  <= '0;
            out_idx_q  <= '0;
            out_last_q <= 1'b0;
        end else begin
            if (row_wr || ((state == COL_OUT) && bus.out_ready)) cnt <= cnt + 1'b1;
            if ((state == COL_WAIT) && bus.dct_done) begin
                out_col_q  <= bus.dct_X;
                out_idx_q  <= cnt;
                out_last_q <= (cnt == CW'(N-1));
            end
        end
    end

    // rst masks the combinational outputs so the reset cycle itself looks idle
    always_comb begin
        bus.in_ready  = 1'b0;
        bus.dct_start = 1'b0;
        bus.dct_x     = '0;
        bus.out_valid = 1'b0;
        case (state)
            ROW_ISSUE: begin
                bus.in_ready  = 1'b1;
                bus.dct_start = bus.in_valid && !rst;
                bus.dct_x     = bus.in_row;
            end
            COL_ISSUE: begin
                bus.dct_start = !rst;
                bus.dct_x     = col_rd;
            end
            COL_OUT:   bus.out_valid = !rst;
            default:   ;
        endcase
        if (rst) bus.in_ready = 1'b1;
        bus.busy = !rst && !((state == ROW_ISSUE) && (cnt == '0));
    end

    assign bus.out_col  = out_col_q;
    assign bus.out_idx  = out_idx_q;
    assign bus.out_last = out_last_q;
endmodule

// File: tb/tb_dct8x8_2d_seq.sv
// Directed bench for dct8x8_2d_seq: table of blocks with hand-computed column results,
// a 1-D unit stub (identity or integer DCT, variable latency, stray done), plus reset and back-to-back runs.
module tb_dct8x8_2d_seq;
    localparam int W = 16;
    localparam int N = 8;

    typedef logic [N-1:0][W-1:0] row_t;
    typedef struct {
        bit                         mode;
        int                         lat_lo;
        int                         lat_hi;
        int                         vin_pct;
        int                         rdy_pct;
        bit                         stray;
        bit                         timing;
        logic [N-1:0][N-1:0][W-1:0] blk;
        logic [N-1:0][N-1:0][W-1:0] exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dct8x8_2d_seq_if #(.W(W), .N(N)) bus ();

    dct8x8_2d_seq #(.W(W), .N(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    vec_t vecs [4];
    int   checks = 0;
    int   errors = 0;
    bit   stub_mode = 1'b0;
    int   lat_lo = 1;
    int   lat_hi = 1;
    bit   stray_en = 1'b0;
    int   stub_starts = 0;
    int   vin_pct = 100;
    int   rdy_pct = 100;

    task automatic check(input string nm, input logic [255:0] act, input logic [255:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, req);
        end
    endtask

    function automatic int ctab(input int m);
        case (m)
            0: return 2048;
            1: return 2009;
            2: return 1892;
            3: return 1703;
            4: return 1448;
            5: return 1138;
            6: return 784;
            7: return 400;
            default: return 0;
        endcase
    endfunction

    // orthonormal 8-point DCT-II, Q12 coefficients, round to nearest
    function automatic row_t dct1d(input row_t x);
        row_t y;
        int   acc, m, cf;
        for (int k = 0; k < N; k++) begin
            acc = 0;
            for (int n = 0; n < N; n++) begin
                m = ((2 * n + 1) * k) % 32;
                if (m > 16) m = 32 - m;
                if (k == 0)     cf = 1448;
                else if (m > 8) cf = -ctab(16 - m);
                else            cf = ctab(m);
                acc += int'($signed(x[n])) * cf;
            end
            y[k] = W'((acc + 2048) >>> 12);
        end
        return y;
    endfunction

    // 1-D unit stub: captures dct_x on start, answers lat cycles later
    initial begin
        row_t xq;
        int   cd;
        cd = 0;
        xq = '0;
        bus.dct_done = 1'b0;
        bus.dct_X    = '0;
        forever begin
            @(negedge clk);
            if (bus.dct_start) begin
                stub_starts++;
                xq = bus.dct_x;
                cd = (lat_lo == lat_hi) ? lat_lo : int'($urandom_range(lat_hi, lat_lo));
            end
            @(posedge clk);
            #1;
            bus.dct_done = 1'b0;
            bus.dct_X    = '0;
            if (cd > 0) begin
                cd--;
                if (cd == 0) begin
                    bus.dct_done = 1'b1;
                    bus.dct_X    = stub_mode ? dct1d(xq) : xq;
                end
            end
            if (!bus.dct_done && stray_en && (bus.in_ready || bus.out_valid) && ($urandom_range(0, 2) == 0)) begin
                bus.dct_done = 1'b1;
                bus.dct_X    = {$urandom, $urandom, $urandom, $urandom};
            end
        end
    end

    // Runs nblk blocks of vector vi; entered and left just after a rising edge.
    // abort_col < 8 stops in the COL_ISSUE cycle of that column (first block only).
    task automatic run_block(input int vi, input int nblk, input bit timing, input int abort_col);
        int   r, c, t, t0, irdy_bad;
        bit   seen, stalled, abort_hit;
        row_t h_col;
        logic [2:0] h_idx;
        logic h_last;
        r = 0; c = 0; t = 0; t0 = 0; irdy_bad = 0;
        seen = 0; stalled = 0; abort_hit = 0;
        h_col = '0; h_idx = '0; h_last = 1'b0;
        stub_starts = 0;
        while (c < 8 * nblk && t < 1000 * nblk) begin
            bus.in_valid  = (r < 8 * nblk) && ($urandom_range(0, 99) < vin_pct);
            bus.in_row    = vecs[vi].blk[r % 8];
            bus.out_ready = ($urandom_range(0, 99) < rdy_pct);
            @(negedge clk);
            if (stalled)
                check("hold", {bus.out_valid, bus.out_idx, bus.out_last, bus.out_col},
                      {1'b1, h_idx, h_last, h_col});
            stalled = 0;
            if (r > 0 && r % 8 == 0 && c < r && bus.in_ready) irdy_bad++;
            if (bus.in_valid && bus.in_ready) begin
                if (r == 0) t0 = t;
                r++;
            end
            if (bus.out_valid) begin
                if (!seen) begin
                    seen = 1;
                    if (timing)
                        check($sformatf("present col%0d cycle", c), t - t0, 18 + 3 * (c % 8) + 40 * (c / 8));
                end
                if (bus.out_ready) begin
                    check($sformatf("v%0d col%0d data", vi, c), bus.out_col, vecs[vi].exp[c % 8]);
                    check($sformatf("col%0d idx", c), bus.out_idx, c % 8);
                    check($sformatf("col%0d last", c), bus.out_last, (c % 8) == 7);
                    c++;
                    seen = 0;
                end else begin
                    stalled = 1;
                    h_col = bus.out_col; h_idx = bus.out_idx; h_last = bus.out_last;
                end
            end
            if (c == abort_col && bus.dct_start) abort_hit = 1;
            @(posedge clk);
            #1;
            t++;
            if (abort_hit) break;
        end
        if (abort_hit) return;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        check("columns done", c, 8 * nblk);
        check("in_ready low in column phase", irdy_bad, 0);
        check("dct_start count", stub_starts, 16 * nblk);
        @(negedge clk);
        check("idle busy", bus.busy, 0);
        check("idle in_ready", bus.in_ready, 1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int r = 0; r < N; r++) begin
            for (int i = 0; i < N; i++) begin
                vecs[0].blk[r][i] = W'(16 * r + i);
                vecs[0].exp[i][r] = W'(16 * r + i);
                vecs[1].blk[r][i] = W'(100);
                vecs[1].exp[r][i] = '0;
                vecs[3].blk[r][i] = W'(-(16 * r + i));
                vecs[3].exp[i][r] = W'(-(16 * r + i));
            end
        end
        vecs[1].exp[0][0] = W'(800);
        vecs[2] = vecs[0];
        vecs[0].mode = 0; vecs[0].lat_lo = 1; vecs[0].lat_hi = 1; vecs[0].vin_pct = 100;
        vecs[0].rdy_pct = 100; vecs[0].stray = 0; vecs[0].timing = 1;
        vecs[1].mode = 1; vecs[1].lat_lo = 1; vecs[1].lat_hi = 1; vecs[1].vin_pct = 100;
        vecs[1].rdy_pct = 100; vecs[1].stray = 0; vecs[1].timing = 1;
        vecs[2].mode = 0; vecs[2].lat_lo = 1; vecs[2].lat_hi = 5; vecs[2].vin_pct = 100;
        vecs[2].rdy_pct = 100; vecs[2].stray = 1; vecs[2].timing = 0;
        vecs[3].mode = 0; vecs[3].lat_lo = 1; vecs[3].lat_hi = 1; vecs[3].vin_pct = 30;
        vecs[3].rdy_pct = 30; vecs[3].stray = 0; vecs[3].timing = 0;

        rst           = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_row    = vecs[0].blk[0];
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset in_ready", bus.in_ready, 1);
        check("reset dct_start", bus.dct_start, 0);
        check("reset out_valid", bus.out_valid, 0);
        check("reset out_last", bus.out_last, 0);
        check("reset out_idx", bus.out_idx, 0);
        check("reset busy", bus.busy, 0);
        check("reset out_col", bus.out_col, 0);
        @(posedge clk);
        #1;
        rst          = 1'b0;
        bus.in_valid = 1'b0;

        for (int v = 0; v < 4; v++) begin
            stub_mode = vecs[v].mode;
            lat_lo    = vecs[v].lat_lo;
            lat_hi    = vecs[v].lat_hi;
            vin_pct   = vecs[v].vin_pct;
            rdy_pct   = vecs[v].rdy_pct;
            stray_en  = vecs[v].stray;
            run_block(v, 1, vecs[v].timing, 8);
        end

        // reset in COL_WAIT of column 3 with the done still in flight
        stub_mode = 0; stray_en = 0; vin_pct = 100; rdy_pct = 100;
        lat_lo = 3; lat_hi = 3;
        run_block(0, 1, 0, 3);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        rst           = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("post-reset out_valid", bus.out_valid, 0);
        check("post-reset busy", bus.busy, 0);
        check("post-reset in_ready", bus.in_ready, 1);
        check("post-reset out_col", bus.out_col, 0);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        check("late done out_valid", bus.out_valid, 0);
        check("late done busy", bus.busy, 0);
        check("late done in_ready", bus.in_ready, 1);
        @(posedge clk);
        #1;
        lat_lo = 1; lat_hi = 1;
        run_block(0, 1, 1, 8);

        run_block(0, 3, 1, 8);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
